// File: rtl/uart_rx_param_if.sv
// Output handshake bundle of the parametrised UART receiver.
//   data_out   : received payload (DATA_BITS wide)
//   data_valid : buffer holds an unconsumed word
//   parity_err : parity mismatch for the buffered word
//   frame_err  : stop bit sampled low for the buffered word
//   data_ready : consumer accepts data_out this cycle
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 data_ready;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with false-start rejection, parity/framing error
// reporting and a one-entry ready/valid output buffer with sticky overrun.
// Ports:
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high
//   tick       : oversample enable; FSM and counters advance only when high
//   serial_in  : asynchronous serial line, idle high
//   clear_err  : clears sticky overrun
//   rx_if      : output buffer handshake (data_out/data_valid/parity_err/frame_err/data_ready)
//   overrun    : sticky, a completed word was dropped
//   busy       : FSM not idle
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             serial_in,
  input  logic             clear_err,
  uart_rx_param_if.master  rx_if,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [BitW-1:0]       bitcnt_q;
  logic [DATA_BITS-1:0]  shreg_q;
  logic                  sync_q, rx_s_q;
  logic                  perr_q;
  logic                  armed_q;   // IDLE only starts after the line has been seen high
  logic [DATA_BITS-1:0]  dout_q;
  logic                  valid_q, pe_q, fe_q, ovr_q;

  logic complete, load;

  // Stop bit sampled this cycle: the frame is done.
  assign complete = tick && (state_q == StStop) && (cnt_q == CntLast);
  // Buffer is free, or is being drained in the same cycle.
  assign load     = complete && (!valid_q || rx_if.data_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      perr_q   <= 1'b0;
      armed_q  <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync_q <= serial_in;
      rx_s_q <= sync_q;

      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s_q && armed_q) begin
              state_q <= StStart;
              cnt_q   <= '0;
            end else if (rx_s_q) begin
              armed_q <= 1'b1;
            end
          end
          StStart: begin
            if (cnt_q == CntHalf) begin
              if (rx_s_q) begin
                // Line returned high by mid start bit: glitch, not a frame.
                state_q <= StIdle;
                armed_q <= 1'b1;
              end else begin
                state_q  <= StData;
                cnt_q    <= '0;
                bitcnt_q <= '0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StData: begin
            if (cnt_q == CntLast) begin
              cnt_q    <= '0;
              shreg_q  <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
              bitcnt_q <= bitcnt_q + 1'b1;
              if (bitcnt_q == BitLast) begin
                state_q <= (PARITY_EN != 0) ? StParity : StStop;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StParity: begin
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              perr_q  <= (^shreg_q) ^ rx_s_q ^ (PARITY_ODD != 0);
              state_q <= StStop;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StStop: begin
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              state_q <= StIdle;
              // A low stop bit must not look like the next start edge.
              armed_q <= rx_s_q;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // Output buffer runs every clock, independent of tick.
      if (load) begin
        dout_q  <= shreg_q;
        pe_q    <= (PARITY_EN != 0) ? perr_q : 1'b0;
        fe_q    <= !rx_s_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_if.data_ready) begin
        valid_q <= 1'b0;
      end

      // A new drop wins over a simultaneous clear.
      if (complete && !load) begin
        ovr_q <= 1'b1;
      end else if (clear_err) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign rx_if.data_out   = dout_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.parity_err = pe_q;
  assign rx_if.frame_err  = fe_q;
  assign overrun          = ovr_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one default instance (8N1) and one with odd parity (8O1).
// A frame-level model predicts when each word lands in the buffer and what it holds;
// a per-cycle compare checks the buffer outputs, and directed checks pin literal values.
module tb_uart_rx_param;
  localparam int OS = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b1;
  logic ser0 = 1'b1, ser1 = 1'b1;
  logic clear_err = 1'b0;
  logic ready = 1'b1;
  logic ovr0, ovr1, busy0, busy1;
  bit   cmp_en = 1'b0;

  int total = 0;
  int bad = 0;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  assign if0.data_ready = ready;
  assign if1.data_ready = ready;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clock(clock), .reset(reset), .tick(tick), .serial_in(ser0), .clear_err(clear_err),
    .rx_if(if0.master), .overrun(ovr0), .busy(busy0)
  );

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
    .clock(clock), .reset(reset), .tick(tick), .serial_in(ser1), .clear_err(clear_err),
    .rx_if(if1.master), .overrun(ovr1), .busy(busy1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int         cyc = 0;        // index of the next rising edge
  int         rst_last = -1;
  int         p_start [2] = '{-1, -1};
  int         p_due [2] = '{-1, -1};
  logic [7:0] p_d [2];
  logic       p_pe [2];
  logic       p_fe [2];
  logic       m_valid [2] = '{1'b0, 1'b0};
  logic [7:0] m_data [2] = '{8'h00, 8'h00};
  logic       m_pe [2] = '{1'b0, 1'b0};
  logic       m_fe [2] = '{1'b0, 1'b0};
  logic       m_ovr [2] = '{1'b0, 1'b0};
  logic       comp, drop;

  always @(posedge clock) begin
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        m_valid[s] = 1'b0; m_data[s] = 8'h00; m_pe[s] = 1'b0; m_fe[s] = 1'b0;
        m_ovr[s] = 1'b0;
      end else begin
        comp = (cyc == p_due[s]) && (p_start[s] > rst_last);
        drop = comp && m_valid[s] && !ready;
        if (comp && !drop) begin
          m_valid[s] = 1'b1; m_data[s] = p_d[s]; m_pe[s] = p_pe[s]; m_fe[s] = p_fe[s];
        end else if (m_valid[s] && ready) begin
          m_valid[s] = 1'b0;
        end
        if (drop) m_ovr[s] = 1'b1;
        else if (clear_err) m_ovr[s] = 1'b0;
      end
    end
    if (reset) rst_last = cyc;
    cyc = cyc + 1;
  end

  task automatic cmp(input int s, input logic v, input logic [7:0] d, input logic pe,
                     input logic fe, input logic ov);
    check($sformatf("cyc%0d_dut%0d_valid", cyc, s), v, m_valid[s]);
    check($sformatf("cyc%0d_dut%0d_overrun", cyc, s), ov, m_ovr[s]);
    if (m_valid[s]) begin
      check($sformatf("cyc%0d_dut%0d_data", cyc, s), d, m_data[s]);
      check($sformatf("cyc%0d_dut%0d_perr", cyc, s), pe, m_pe[s]);
      check($sformatf("cyc%0d_dut%0d_ferr", cyc, s), fe, m_fe[s]);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      cmp(0, if0.data_valid, if0.data_out, if0.parity_err, if0.frame_err, ovr0);
      cmp(1, if1.data_valid, if1.data_out, if1.parity_err, if1.frame_err, ovr1);
    end
  end

  // ---------------- capture of each data_valid rise ----------------
  int         rises [2] = '{0, 0};
  int         rise_cyc [2] = '{0, 0};
  logic [7:0] cap_d [2];
  logic       cap_pe [2];
  logic       cap_fe [2];
  logic       pv [2] = '{1'b0, 1'b0};

  task automatic mon(input int s, input logic v, input logic [7:0] d, input logic pe,
                     input logic fe);
    if (v === 1'b1 && pv[s] !== 1'b1) begin
      rises[s]++;
      rise_cyc[s] = cyc - 1;
      cap_d[s] = d; cap_pe[s] = pe; cap_fe[s] = fe;
    end
    pv[s] = v;
  endtask

  always @(negedge clock) begin
    mon(0, if0.data_valid, if0.data_out, if0.parity_err, if0.frame_err);
    mon(1, if1.data_valid, if1.data_out, if1.parity_err, if1.frame_err);
  end

  // ---------------- stimulus ----------------
  task automatic drive_bit(input int s, input logic val);
    if (s == 0) ser0 = val;
    else ser1 = val;
    repeat (OS) @(negedge clock);
  endtask

  task automatic send(input int s, input logic [7:0] d, input logic pbit, input logic stop);
    @(negedge clock);
    p_start[s] = cyc;
    p_due[s]   = cyc + 2 + OS / 2 + (8 + s + 1) * OS;
    p_d[s]     = d;
    p_pe[s]    = (s == 1) ? ((^d) ^ pbit ^ 1'b1) : 1'b0;
    p_fe[s]    = !stop;
    drive_bit(s, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(s, d[i]);
    if (s == 1) drive_bit(s, pbit);
    drive_bit(s, stop);
    if (s == 0) ser0 = 1'b1;
    else ser1 = 1'b1;
  endtask

  int r0, nb;
  logic [7:0] part;

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    cmp_en = 1'b1;
    check("rst_valid", if0.data_valid, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_overrun", ovr0, 1'b0);
    check("rst_data", if0.data_out, 8'h00);
    check("rst_busy1", busy1, 1'b0);
    repeat (20) @(negedge clock);

    // 1: 0xA5, latency and single-cycle valid pulse
    r0 = rises[0];
    send(0, 8'hA5, 1'b0, 1'b1);
    repeat (5) @(negedge clock);
    check("t1_rises", rises[0] - r0, 1);
    check("t1_latency", rise_cyc[0] - p_start[0], 154);
    check("t1_data", cap_d[0], 8'hA5);
    check("t1_ferr", cap_fe[0], 1'b0);
    check("t1_perr", cap_pe[0], 1'b0);
    check("t1_valid_gone", if0.data_valid, 1'b0);

    // 2: glitch of 5 clocks is rejected
    repeat (10) @(negedge clock);
    r0 = rises[0];
    ser0 = 1'b0;
    nb = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (busy0 === 1'b1) nb++;
      if (k == 5) ser0 = 1'b1;
    end
    check("t2_busy_cycles", nb, 8);
    check("t2_no_word", rises[0] - r0, 0);
    check("t2_idle", busy0, 1'b0);

    // 3: framing error, then a good frame clears it
    r0 = rises[0];
    send(0, 8'h3C, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    check("t3_rises", rises[0] - r0, 1);
    check("t3_data", cap_d[0], 8'h3C);
    check("t3_ferr", cap_fe[0], 1'b1);
    repeat (20) @(negedge clock);
    send(0, 8'h00, 1'b0, 1'b1);
    repeat (5) @(negedge clock);
    check("t3b_rises", rises[0] - r0, 2);
    check("t3b_data", cap_d[0], 8'h00);
    check("t3b_ferr", cap_fe[0], 1'b0);

    // 4: odd parity on the second instance
    r0 = rises[1];
    send(1, 8'h07, 1'b0, 1'b1);
    repeat (5) @(negedge clock);
    check("t4_data", cap_d[1], 8'h07);
    check("t4_perr_ok", cap_pe[1], 1'b0);
    check("t4_ferr", cap_fe[1], 1'b0);
    send(1, 8'h07, 1'b1, 1'b1);
    repeat (5) @(negedge clock);
    check("t4_rises", rises[1] - r0, 2);
    check("t4_perr_bad", cap_pe[1], 1'b1);

    // 5: overrun with consumer stalled
    ready = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    repeat (5) @(negedge clock);
    check("t5_held_data", if0.data_out, 8'h11);
    check("t5_valid", if0.data_valid, 1'b1);
    check("t5_overrun", ovr0, 1'b1);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    check("t5_overrun_clr", ovr0, 1'b0);
    check("t5_still_valid", if0.data_valid, 1'b1);
    ready = 1'b1;
    @(negedge clock);
    check("t5_valid_drop", if0.data_valid, 1'b0);

    // 6: reset in the middle of bit 4
    repeat (10) @(negedge clock);
    part = 8'hC3;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, part[i]);
    ser0 = part[4];
    repeat (OS / 2) @(negedge clock);
    check("t6_busy_before", busy0, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ser0 = 1'b1;
    check("t6_busy", busy0, 1'b0);
    check("t6_valid", if0.data_valid, 1'b0);
    check("t6_data", if0.data_out, 8'h00);
    check("t6_overrun", ovr0, 1'b0);
    check("t6_perr", if0.parity_err, 1'b0);
    check("t6_ferr", if0.frame_err, 1'b0);
    repeat (40) @(negedge clock);
    r0 = rises[0];
    send(0, 8'h5A, 1'b0, 1'b1);
    repeat (5) @(negedge clock);
    check("t6_rises", rises[0] - r0, 1);
    check("t6_data_after", cap_d[0], 8'h5A);
    check("t6_ferr_after", cap_fe[0], 1'b0);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
